// File: rtl/uart_word_engine.sv
// Word-to-byte engine between the core IO unit and the UART RX/TX byte buffers.
// Splits 1..WORD_BYTES byte transfers into handshakes, with endianness, RX extension and byte-gap timeout.
module uart_word_engine #(
    parameter int WORD_BYTES = 4,
    parameter int SIZE_W     = 2,
    parameter int TIMEOUT    = 0,
    parameter int CNT_W      = 24
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    order,
    output logic                    accepted,
    output logic                    done,
    output logic                    error,
    input  logic [SIZE_W-1:0]       size,
    input  logic                    write_flag,
    input  logic                    unsigned_flag,
    input  logic                    little_endian,
    input  logic [8*WORD_BYTES-1:0] write_data,
    output logic [8*WORD_BYTES-1:0] read_data,
    output logic                    i_order,
    input  logic [7:0]              i_data,
    input  logic                    i_done,
    output logic                    o_order,
    output logic [7:0]              o_data,
    input  logic                    o_done
);
    localparam int W       = 8 * WORD_BYTES;
    localparam int LOG2_WB = $clog2(WORD_BYTES);
    localparam int NB_W    = LOG2_WB + 1;
    localparam int IDX_W   = (LOG2_WB > 0) ? LOG2_WB : 1;

    typedef enum logic [1:0] {IDLE, RX, TX} state_e;

    state_e           state_q, state_d;
    logic [NB_W-1:0]  len_q, len_d, rem_q, rem_d, n_req;
    logic [IDX_W-1:0] idx_q, idx_d, idx_start;
    logic             uns_q, uns_d, le_q, le_d;
    logic [W-1:0]     data_q, data_d, rx_q, rx_d, rd_q, rd_d, rx_next;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d, err_q, err_d;
    logic             iord_q, iord_d, oord_q, oord_d;
    logic [7:0]       odata_q, odata_d;
    logic             hs, last, tmo;

    function automatic logic [7:0] byte_at(input logic [W-1:0] v, input logic [IDX_W-1:0] i);
        logic [W-1:0] s;
        s = v >> {i, 3'b000};
        return s[7:0];
    endfunction

    // The sign bit 8n-1 is isolated as the top bit of the low-n-byte mask.
    function automatic logic [W-1:0] extend(input logic [W-1:0] v, input logic [NB_W-1:0] nb,
                                            input logic uns);
        logic [W-1:0] hi, msb;
        hi  = {W{1'b1}};
        hi  = hi << {nb, 3'b000};
        msb = ~hi ^ (~hi >> 1);
        if (!uns && |(v & msb)) return v | hi;
        return v & ~hi;
    endfunction

    assign accepted  = order & (state_q == IDLE);
    assign hs        = ((state_q == RX) && i_done) || ((state_q == TX) && o_done);
    assign last      = hs && (rem_q == NB_W'(1));
    assign tmo       = (TIMEOUT != 0) && (state_q != IDLE) && !hs && (cnt_q == '0);
    assign idx_start = IDX_W'(n_req - 1'b1);
    assign rx_next   = le_q ? (rx_q | (W'(i_data) << {idx_q, 3'b000})) : ((rx_q << 8) | W'(i_data));

    always_comb begin
        if (int'(size) >= LOG2_WB) n_req = NB_W'(WORD_BYTES);
        else                       n_req = NB_W'(1) << size;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            len_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            uns_q   <= 1'b0;
            le_q    <= 1'b0;
            data_q  <= '0;
            rx_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            iord_q  <= 1'b0;
            oord_q  <= 1'b0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            uns_q   <= uns_d;
            le_q    <= le_d;
            data_q  <= data_d;
            rx_q    <= rx_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            iord_q  <= iord_d;
            oord_q  <= oord_d;
            odata_q <= odata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (order) state_d = write_flag ? TX : RX;
            RX, TX:  if (last || tmo) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        len_d   = len_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        uns_d   = uns_q;
        le_d    = le_q;
        data_d  = data_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        iord_d  = iord_q;
        oord_d  = oord_q;
        odata_d = odata_q;
        case (state_q)
            IDLE: if (order) begin
                len_d  = n_req;
                rem_d  = n_req;
                uns_d  = unsigned_flag;
                le_d   = little_endian;
                data_d = write_data;
                rx_d   = '0;
                cnt_d  = CNT_W'(TIMEOUT);
                idx_d  = little_endian ? '0 : idx_start;
                iord_d = ~write_flag;
                oord_d = write_flag;
                if (write_flag) odata_d = byte_at(write_data, idx_d);
            end
            TX: if (o_done) begin
                rem_d = rem_q - 1'b1;
                cnt_d = CNT_W'(TIMEOUT);
                if (last) begin
                    oord_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    idx_d   = le_q ? idx_q + 1'b1 : idx_q - 1'b1;
                    odata_d = byte_at(data_q, idx_d);
                end
            end else if (tmo) begin
                oord_d = 1'b0;
                done_d = 1'b1;
                err_d  = 1'b1;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
            RX: if (i_done) begin
                rx_d  = rx_next;
                rem_d = rem_q - 1'b1;
                idx_d = idx_q + 1'b1;
                cnt_d = CNT_W'(TIMEOUT);
                if (last) begin
                    iord_d = 1'b0;
                    done_d = 1'b1;
                    rd_d   = extend(rx_next, len_q, uns_q);
                end
            end else if (tmo) begin
                iord_d = 1'b0;
                done_d = 1'b1;
                err_d  = 1'b1;
                rd_d   = '0;
                rx_d   = '0;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    assign done      = done_q;
    assign error     = err_q;
    assign read_data = rd_q;
    assign i_order   = iord_q;
    assign o_order   = oord_q;
    assign o_data    = odata_q;

endmodule
